fifo_port_arbiter: RTL
======================

Name: fifo_port_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 32-bit host-bound output FIFO write port between N_REQ user cores.
- Each core presents a valid/ready word stream with an end-of-packet marker.
- The arbiter locks a grant for a whole packet, forwards the words into the FIFO, and rotates priority.
- Sits between the sensor/compute cores and the output FIFO that feeds the host read channel.

Parameters:
N_REQ, 4, number of requesters (2..8).
DATA_W, 32, word width; equals the FIFO width.
MAX_LEN, 256, maximum words per packet before a forced close (1..65535).

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester word valid
req_data  input  N_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
req_last  input  N_REQ  marks the final word of a packet; qualified by valid
req_ready  output  N_REQ  word accepted this cycle (valid && ready = transfer)
fifo_din  output  DATA_W  FIFO write data
fifo_wr_en  output  1  FIFO write strobe
fifo_full  input  1  FIFO full flag
grant_valid  output  1  a packet is currently owned
grant_id  output  3  index of the owning requester
pkt_done  output  1  one-cycle pulse when a packet closes
trunc_err  output  1  one-cycle pulse when a packet is force-closed at MAX_LEN

Behaviour:
- Registered state machine with states IDLE and XFER (plus HDR when the optional feature is enabled).
- Reset values:
  - state = IDLE, last_grant = N_REQ-1, so requester 0 wins first.
  - grant_valid = 0, grant_id = 0, word count = 0.
  - pkt_done = 0, trunc_err = 0, req_ready = 0, fifo_wr_en = 0.
- IDLE:
  - If any req_valid is high, select the first requester with valid set, searching (last_grant+1) mod N_REQ upward with wrap.
  - On the next edge: grant_id = selected, grant_valid = 1, state = XFER.
  - Arbitration latency is 1 cycle. No word is transferred in IDLE.
- XFER:
  - req_ready[g] = (g == grant_id) && !fifo_full. All other ready bits are 0.
  - Transfer is combinational: xfer = req_valid[grant_id] && req_ready[grant_id].
  - fifo_wr_en = xfer, fifo_din = req_data of grant_id. Zero added latency.
  - fifo_wr_en is never high while fifo_full = 1.
  - Each xfer increments the word count.
  - On an xfer with req_last = 1:
    - pkt_done pulses on the next cycle.
    - last_grant = grant_id, grant_valid = 0, count = 0, state = IDLE.
  - On an xfer where the count reaches MAX_LEN and req_last = 0:
    - Close exactly as for a normal last word; pkt_done and trunc_err both pulse.
    - The requester's remaining words are arbitrated as a new packet.
- The requester may drop req_valid mid-packet; the grant is held indefinitely (no timeout).
- Other requesters' valid signals are ignored while a grant is held.
- A requester whose valid rises while the arbiter is in IDLE competes at the next IDLE evaluation only.
- Back-to-back packets: the minimum gap is 1 IDLE cycle between the last word and the next first word.
- A single requester asserting continuously is re-granted after each IDLE cycle.
- Reset mid-packet: immediate return to reset values. The partial packet stays in the FIFO; no flush.
- Word count width is ceil(log2(MAX_LEN+1)).

Optional Feature:
- Macro: FIFO_PORT_ARBITER_HDR_EN.
- When defined:
  - IDLE goes to HDR instead of XFER.
  - In HDR, when !fifo_full, write one header word: fifo_din = {8'hA5, 5'b0, grant_id[2:0], pkt_seq[15:0]}, fifo_wr_en = 1.
  - Then move to XFER.
  - req_ready stays 0 during HDR.
  - pkt_seq is a 16-bit counter, reset 0, incremented at each header write, wrapping 16'hFFFF to 0.
  - The header does not count toward MAX_LEN.
- When undefined: no HDR state, no pkt_seq, and the timing described above applies.

Test Plan:
- Single packet: rst, then req 2 sends 3 words 0x11,0x22,0x33 (last on 0x33), FIFO never full -> grant_id = 2 after 1 cycle, three consecutive fifo_wr_en with the same data, then pkt_done pulse and grant_valid = 0.
- Round-robin: all four requesters hold 1-word packets continuously -> grant order 0,1,2,3,0 with one IDLE cycle between packets.
- Backpressure: fifo_full = 1 for 5 cycles mid-packet of req 1 -> req_ready[1] = 0 and fifo_wr_en = 0 for those 5 cycles; no word is lost or duplicated after release.
- Truncation: MAX_LEN = 4, req 0 streams 6 words with last only on word 6 -> first 4 words written, then trunc_err and pkt_done pulse; the remaining 2 words follow as a new packet.
- Reset mid-packet: rst asserted after 2 of 5 words -> all outputs at reset values next cycle; the next grant goes to requester 0 if valid.
- HDR_EN: req 3 sends 2 words on first and second packets -> header words 0xA5030000 then 0xA5030001 precede each packet's data.

Source files
------------

// File: rtl/fifo_port_arbiter.sv
// ============================================================================
//  Module   : fifo_port_arbiter
//  Purpose  : Packet-granular round-robin arbiter sharing one host-bound
//             output FIFO write port between N_REQ user cores. A grant is
//             locked for a whole packet (or until MAX_LEN words), words are
//             forwarded combinationally into the FIFO, then priority rotates.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock
//    rst          in   synchronous active-high reset
//    req_valid    in   [N_REQ]        per-requester word valid
//    req_data     in   [N_REQ*DATA_W] requester i at [i*DATA_W +: DATA_W]
//    req_last     in   [N_REQ]        final word of a packet
//    req_ready    out  [N_REQ]        word accepted this cycle
//    fifo_din     out  [DATA_W]       FIFO write data
//    fifo_wr_en   out                 FIFO write strobe
//    fifo_full    in                  FIFO full flag
//    grant_valid  out                 a packet is currently owned
//    grant_id     out  [3]            owning requester index
//    pkt_done     out                 pulse after a packet closes
//    trunc_err    out                 pulse after a forced close at MAX_LEN
//  Optional feature
//    FIFO_PORT_ARBITER_HDR_EN : prepend a header word
//                               {8'hA5, 5'b0, grant_id, pkt_seq} per packet
// ============================================================================
`default_nettype none

module fifo_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         fifo_din,
  output logic                      fifo_wr_en,
  input  logic                      fifo_full,
  output logic                      grant_valid,
  output logic [2:0]                grant_id,
  output logic                      pkt_done,
  output logic                      trunc_err
);

  localparam int               CNT_W          = $clog2(MAX_LEN + 1);
  localparam logic [2:0]       LAST_GRANT_RST = 3'(N_REQ - 1);
  // Count value before the transfer that makes the packet MAX_LEN words long
  localparam logic [CNT_W-1:0] CNT_CLOSE      = CNT_W'(MAX_LEN - 1);

`ifdef FIFO_PORT_ARBITER_HDR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, HDR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic             grant_valid_nxt;
  logic [2:0]       grant_id_nxt;
  logic [2:0]       last_grant, last_grant_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             pkt_done_nxt;
  logic             trunc_err_nxt;
`ifdef FIFO_PORT_ARBITER_HDR_EN
  logic [15:0]      pkt_seq, pkt_seq_nxt;
`endif

  logic             arb_found;
  logic [2:0]       arb_sel;
  logic             sel_valid;
  logic             sel_last;
  logic [DATA_W-1:0] sel_data;
  logic             xfer;

  // Round-robin search: offset 1 from last_grant has the highest priority,
  // offset N_REQ (last_grant itself) the lowest.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!arb_found && req_valid[i] &&
            (i == ((int'(last_grant) + k) % N_REQ))) begin
          arb_found = 1'b1;
          arb_sel   = 3'(i);
        end
      end
    end
  end

  // Lane multiplexer for the currently granted requester
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt       = state;
    grant_valid_nxt = grant_valid;
    grant_id_nxt    = grant_id;
    last_grant_nxt  = last_grant;
    count_nxt       = count;
    pkt_done_nxt    = 1'b0;
    trunc_err_nxt   = 1'b0;
`ifdef FIFO_PORT_ARBITER_HDR_EN
    pkt_seq_nxt     = pkt_seq;
`endif
    req_ready       = '0;
    fifo_wr_en      = 1'b0;
    fifo_din        = sel_data;
    xfer            = 1'b0;

    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_id_nxt    = arb_sel;
          grant_valid_nxt = 1'b1;
`ifdef FIFO_PORT_ARBITER_HDR_EN
          state_nxt       = HDR;
`else
          state_nxt       = XFER;
`endif
        end
      end

`ifdef FIFO_PORT_ARBITER_HDR_EN
      HDR: begin
        fifo_din = DATA_W'({8'hA5, 5'b0, grant_id, pkt_seq});
        if (!fifo_full) begin
          fifo_wr_en  = 1'b1;
          pkt_seq_nxt = pkt_seq + 16'd1;
          state_nxt   = XFER;
        end
      end
`endif

      XFER: begin
        for (int i = 0; i < N_REQ; i++) begin
          req_ready[i] = (grant_id == 3'(i)) && !fifo_full;
        end
        xfer       = sel_valid && !fifo_full;
        fifo_wr_en = xfer;
        if (xfer) begin
          count_nxt = count + CNT_W'(1);
          // A last word arriving exactly at MAX_LEN is a normal close
          if (sel_last || (count == CNT_CLOSE)) begin
            pkt_done_nxt    = 1'b1;
            trunc_err_nxt   = !sel_last;
            last_grant_nxt  = grant_id;
            grant_valid_nxt = 1'b0;
            count_nxt       = '0;
            state_nxt       = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_grant  <= LAST_GRANT_RST;
      count       <= '0;
      pkt_done    <= 1'b0;
      trunc_err   <= 1'b0;
`ifdef FIFO_PORT_ARBITER_HDR_EN
      pkt_seq     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      grant_valid <= grant_valid_nxt;
      grant_id    <= grant_id_nxt;
      last_grant  <= last_grant_nxt;
      count       <= count_nxt;
      pkt_done    <= pkt_done_nxt;
      trunc_err   <= trunc_err_nxt;
`ifdef FIFO_PORT_ARBITER_HDR_EN
      pkt_seq     <= pkt_seq_nxt;
`endif
    end
  end

endmodule

`default_nettype wire
